// File: rtl/drc_pkg.sv
// rtl/drc_pkg.sv - shared DRC register map, bit positions, mode and capture-state encodings
package drc_pkg;

  // CSR word indices
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_START    = 3'd1;
  localparam logic [2:0] REG_IMG_DIM  = 3'd2;
  localparam logic [2:0] REG_IRQ_MSK  = 3'd3;
  localparam logic [2:0] REG_IRQ_PEND = 3'd4;
  localparam logic [2:0] REG_STATUS   = 3'd5;

  // CTRL fields
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;

  // IRQ_MSK / IRQ_PEND bit positions
  localparam int PEND_COMP_BIT = 0;
  localparam int PEND_ERR_BIT  = 1;
  localparam int PEND_OVF_BIT  = 2;

  // Capture modes, also decoded by the capture state machine
  typedef enum logic [1:0] {
    MODE_SLEEP  = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_STREAM = 2'd2
  } drc_mode_e;

  // Capture state machine encodings
  typedef enum logic [2:0] {
    ST_SLEEP    = 3'd0,
    ST_IDLE     = 3'd1,
    ST_ALIGN    = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_ERR_CORR = 3'd4
  } drc_state_e;

  // Dimensions may only change while no frame is in flight
  function automatic logic is_quiescent(input logic [2:0] st);
    return (st == ST_SLEEP) || (st == ST_IDLE);
  endfunction

endpackage

// File: rtl/drc_csr_ctrl_if.sv
// rtl/drc_csr_ctrl_if.sv - valid/ready CSR request/response port
interface drc_csr_ctrl_if;
  logic        csr_req_vld;
  logic        csr_req_rdy;
  logic        csr_req_wr;
  logic [2:0]  csr_req_addr;
  logic [31:0] csr_req_wdat;
  logic        csr_rsp_vld;
  logic        csr_rsp_rdy;
  logic [31:0] csr_rsp_dat;
  logic        csr_rsp_err;

  modport master (
    output csr_req_vld, csr_req_wr, csr_req_addr, csr_req_wdat, csr_rsp_rdy,
    input  csr_req_rdy, csr_rsp_vld, csr_rsp_dat, csr_rsp_err
  );

  modport slave (
    input  csr_req_vld, csr_req_wr, csr_req_addr, csr_req_wdat, csr_rsp_rdy,
    output csr_req_rdy, csr_rsp_vld, csr_rsp_dat, csr_rsp_err
  );
endinterface

// File: rtl/drc_start_queue.sv
// rtl/drc_start_queue.sv - bounded software start-request occupancy counter
module drc_start_queue #(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [LVL_W-1:0] lvl_o,
  output logic             start_o,
  output logic             ovf_o
);

  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             full, empty, push_ok, pop_ok;

  assign full    = (lvl_q == LVL_W'(DEPTH));
  assign empty   = (lvl_q == '0);
  // a pop in the same cycle frees the slot a full-queue push needs
  assign push_ok = push_i & (~full | pop_i);
  assign pop_ok  = pop_i & ~empty;
  assign ovf_o   = push_i & full & ~pop_i;

  // next occupancy: flush wins, otherwise net of accepted push/pop
  always_comb begin
    lvl_d = lvl_q;
    if (flush_i) begin
      lvl_d = '0;
    end else if (push_ok && !pop_ok) begin
      lvl_d = lvl_q + LVL_W'(1);
    end else if (pop_ok && !push_ok) begin
      lvl_d = lvl_q - LVL_W'(1);
    end
  end

  // occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_q <= '0;
    else        lvl_q <= lvl_d;
  end

  assign lvl_o   = lvl_q;
  assign start_o = ~empty;

endmodule

// File: rtl/drc_csr_ctrl.sv
// rtl/drc_csr_ctrl.sv - DRC CSR block: control, start queue, dimension shadow, sticky IRQs
module drc_csr_ctrl
  import drc_pkg::*;
#(
  parameter int IMG_DIM_MAX   = 640,
  parameter int IMG_DIM_W     = $clog2(IMG_DIM_MAX),
  parameter int IMG_W_RST     = 640,
  parameter int IMG_H_RST     = 480,
  parameter int START_Q_DEPTH = 4,
  parameter int START_Q_W     = $clog2(START_Q_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  drc_csr_ctrl_if.slave          csr,
  output logic                   cam_rx_en_o,
  output logic [1:0]             cam_rx_mode_o,
  output logic                   cam_rx_start_o,
  input  logic                   cam_rx_start_qed_i,
  input  logic [2:0]             cam_rx_state_i,
  input  logic [2*IMG_DIM_W-1:0] cam_rx_len_i,
  output logic [IMG_DIM_W-1:0]   img_width_o,
  output logic [IMG_DIM_W-1:0]   img_height_o,
  output logic                   irq_msk_frm_comp_o,
  output logic                   irq_msk_frm_err_o,
  input  logic                   irq_frm_comp_i,
  input  logic                   irq_frm_err_i,
  output logic                   irq_o
);

  logic                 rsp_vld_q, rsp_vld_d, rsp_err_q, rsp_err_d;
  logic [31:0]          rsp_dat_q, rsp_dat_d, rd_dat;
  logic                 en_q, en_d;
  logic [1:0]           mode_q, mode_d;
  logic [IMG_DIM_W-1:0] width_q, width_d, height_q, height_d;
  logic [IMG_DIM_W-1:0] shw_q, shw_d, shh_q, shh_d;
  logic                 dim_pend_q, dim_pend_d;
  logic [1:0]           msk_q, msk_d;
  logic [2:0]           pend_q, pend_d, w1c;
  logic                 irq_q, irq_d;
  logic                 req_acc, wr_acc, q_push, q_flush, q_ovf;
  logic [START_Q_W-1:0] q_lvl;
  logic                 unused_wdat;

  assign csr.csr_req_rdy = ~rsp_vld_q | csr.csr_rsp_rdy;
  assign req_acc = csr.csr_req_vld & csr.csr_req_rdy;
  assign wr_acc  = req_acc & csr.csr_req_wr;
  assign q_push  = wr_acc & (csr.csr_req_addr == REG_START);
  assign q_flush = wr_acc & (csr.csr_req_addr == REG_CTRL) & ~csr.csr_req_wdat[CTRL_EN_BIT];
  assign unused_wdat = ^csr.csr_req_wdat;

  drc_start_queue #(.DEPTH(START_Q_DEPTH), .LVL_W(START_Q_W)) u_start_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (q_push),
    .pop_i   (cam_rx_start_qed_i),
    .flush_i (q_flush),
    .lvl_o   (q_lvl),
    .start_o (cam_rx_start_o),
    .ovf_o   (q_ovf)
  );

  // read-data mux; STATUS captures the live pixel count at the read
  always_comb begin
    rd_dat = '0;
    case (csr.csr_req_addr)
      REG_CTRL: begin
        rd_dat[CTRL_EN_BIT]                 = en_q;
        rd_dat[CTRL_MODE_LSB +: 2]          = mode_q;
      end
      REG_START:    rd_dat[START_Q_W-1:0]   = q_lvl;
      REG_IMG_DIM: begin
        rd_dat[IMG_DIM_W-1:0]               = shw_q;
        rd_dat[16 +: IMG_DIM_W]             = shh_q;
      end
      REG_IRQ_MSK:  rd_dat[1:0]             = msk_q;
      REG_IRQ_PEND: rd_dat[2:0]             = pend_q;
      REG_STATUS: begin
        rd_dat[2:0]                         = cam_rx_state_i;
        rd_dat[3]                           = dim_pend_q;
        rd_dat[4 +: 2*IMG_DIM_W]            = cam_rx_len_i;
      end
      default:      rd_dat                  = '0;
    endcase
  end

  // next-state for the response slot, register writes, shadow copy and sticky IRQs
  always_comb begin
    rsp_vld_d  = rsp_vld_q;
    rsp_dat_d  = rsp_dat_q;
    rsp_err_d  = rsp_err_q;
    en_d       = en_q;
    mode_d     = mode_q;
    width_d    = width_q;
    height_d   = height_q;
    shw_d      = shw_q;
    shh_d      = shh_q;
    dim_pend_d = dim_pend_q;
    msk_d      = msk_q;
    w1c        = '0;

    if (req_acc) begin
      rsp_vld_d = 1'b1;
      rsp_dat_d = csr.csr_req_wr ? 32'd0 : rd_dat;
      rsp_err_d = (csr.csr_req_addr > REG_STATUS);
    end else if (csr.csr_rsp_rdy) begin
      rsp_vld_d = 1'b0;
    end

    // an old pending shadow lands first; a write this cycle re-arms it
    if (dim_pend_q && is_quiescent(cam_rx_state_i)) begin
      width_d    = shw_q;
      height_d   = shh_q;
      dim_pend_d = 1'b0;
    end

    if (wr_acc) begin
      case (csr.csr_req_addr)
        REG_CTRL: begin
          en_d   = csr.csr_req_wdat[CTRL_EN_BIT];
          mode_d = csr.csr_req_wdat[CTRL_MODE_LSB +: 2];
        end
        REG_IMG_DIM: begin
          shw_d      = csr.csr_req_wdat[IMG_DIM_W-1:0];
          shh_d      = csr.csr_req_wdat[16 +: IMG_DIM_W];
          dim_pend_d = 1'b1;
        end
        REG_IRQ_MSK:  msk_d = csr.csr_req_wdat[1:0];
        REG_IRQ_PEND: w1c   = csr.csr_req_wdat[2:0];
        default: ;
      endcase
    end

    // set beats clear when both hit the same bit
    pend_d = (pend_q & ~w1c) | {q_ovf, irq_frm_err_i, irq_frm_comp_i};
    irq_d  = |(pend_d[PEND_ERR_BIT:PEND_COMP_BIT] & msk_d) | pend_d[PEND_OVF_BIT];
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q  <= 1'b0;
      rsp_dat_q  <= '0;
      rsp_err_q  <= 1'b0;
      en_q       <= 1'b0;
      mode_q     <= MODE_SLEEP;
      width_q    <= IMG_DIM_W'(IMG_W_RST);
      height_q   <= IMG_DIM_W'(IMG_H_RST);
      shw_q      <= IMG_DIM_W'(IMG_W_RST);
      shh_q      <= IMG_DIM_W'(IMG_H_RST);
      dim_pend_q <= 1'b0;
      msk_q      <= '0;
      pend_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      rsp_vld_q  <= rsp_vld_d;
      rsp_dat_q  <= rsp_dat_d;
      rsp_err_q  <= rsp_err_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      width_q    <= width_d;
      height_q   <= height_d;
      shw_q      <= shw_d;
      shh_q      <= shh_d;
      dim_pend_q <= dim_pend_d;
      msk_q      <= msk_d;
      pend_q     <= pend_d;
      irq_q      <= irq_d;
    end
  end

  assign csr.csr_rsp_vld    = rsp_vld_q;
  assign csr.csr_rsp_dat    = rsp_dat_q;
  assign csr.csr_rsp_err    = rsp_err_q;
  assign cam_rx_en_o        = en_q;
  assign cam_rx_mode_o      = mode_q;
  assign img_width_o        = width_q;
  assign img_height_o       = height_q;
  assign irq_msk_frm_comp_o = msk_q[PEND_COMP_BIT];
  assign irq_msk_frm_err_o  = msk_q[PEND_ERR_BIT];
  assign irq_o              = irq_q;

endmodule
